interval_meter: RTL and testbench
=================================

Name: interval_meter

Overview:
- Measures elapsed time in milliseconds between a `start` pulse and a `stop` pulse, for example a reaction time from stimulus to button press.
- It is the receiving end of the periodic tick scheme: it divides `clk` into 1 ms ticks internally and accumulates them, rather than emitting ticks.
- Sits between the game-control FSM and the display path. The result is held with a valid/ack handshake until the consumer takes it.

Parameters:
- CLKS_PER_MS, 50000: `clk` cycles per millisecond tick. Must be >= 2.
- MAX_MS, 9999: timeout ceiling in ms. Must be < 2**CNT_W.
- CNT_W, 16: width of the ms counter and of `result_ms`.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse; begins a measurement
- stop  input  1  single-cycle pulse; ends a measurement (debounced upstream)
- ack  input  1  consumer accepts the held result
- busy  output  1  high while measuring (state RUN)
- result_valid  output  1  result held and not yet acked
- result_ms  output  CNT_W  measured interval in ms
- timeout  output  1  result is a timeout (qualified by `result_valid`)

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous, active-high.
- Reset values: state=IDLE; prescaler=0; ms_cnt=0; `busy`=0; `result_valid`=0; `result_ms`=0; `timeout`=0.
- Reset mid-measurement aborts the run with no result.
- All outputs are registered.

- States: IDLE, RUN, DONE. With the optional feature compiled in, CONV is added (see Optional Feature).

- IDLE:
  - `start`=1 -> RUN; prescaler and ms_cnt cleared.
  - `stop` is ignored.
  - `start` and `stop` in the same cycle: start wins, stop is dropped.

- RUN:
  - `busy`=1.
  - Prescaler counts 0..CLKS_PER_MS-1 and wraps. On wrap, ms_cnt increments by 1.
  - `stop`=1 -> `result_ms` <= ms_cnt (value before any same-cycle increment), `timeout` <= 0, go to DONE.
  - If ms_cnt == MAX_MS and the prescaler wraps with no `stop`: `result_ms` <= MAX_MS, `timeout` <= 1, go to DONE.
  - `stop` on the same cycle as the timeout wrap: stop wins, `timeout`=0, `result_ms`=MAX_MS.
  - `start` during RUN is ignored; there is no restart.

- DONE:
  - `result_valid`=1; `result_ms` and `timeout` are stable.
  - `ack`=1 -> `result_valid` <= 0, go to IDLE. `result_ms` and `timeout` keep their last values.
  - `ack` and `start` in the same cycle -> go directly to RUN; `result_valid` <= 0 next cycle.
  - `start` without `ack` is ignored.
  - `stop` is ignored.

- Latency:
  - `stop` at cycle N -> `result_valid`=1 at N+1.
  - `ack` at cycle M -> `result_valid`=0 at M+1.

- Arithmetic: the prescaler width is $clog2(CLKS_PER_MS). ms_cnt never exceeds MAX_MS, so no wrap is possible.

Optional Feature:
- Macro: INTERVAL_METER_BCD_EN.
- Defined:
  - Adds output `result_bcd` [15:0]: four BCD digits of `result_ms` for the 7-segment path.
  - Conversion is iterative shift-add-3 (double dabble), one bit per cycle.
  - On leaving RUN the FSM enters CONV for exactly CNT_W cycles, then DONE.
  - `result_valid` rises only with `result_bcd` valid, so `stop` at N -> `result_valid` at N+1+CNT_W.
  - `busy` stays 1 during CONV.
  - `start`, `stop` and `ack` are ignored in CONV.
  - MAX_MS must be <= 9999.
  - `result_bcd` resets to 0.
- Undefined: no `result_bcd` port; no CONV state; latency as in Behaviour.

Decomposition:
- Package `interval_pkg`:
  - state enum `interval_state_t` {IDLE, RUN, CONV, DONE}
  - localparam BCD_DIGITS=4
  - function for prescaler width
- Sub-module `bin2bcd_seq`, instantiated only under INTERVAL_METER_BCD_EN:
  - Ports: `clk`, `reset`, `load`, `bin` [CNT_W-1:0], `done`, `bcd` [15:0].
  - Fixed CNT_W-cycle latency.

Test Plan (CLKS_PER_MS=4, MAX_MS=20, CNT_W=16 for speed):
1. `start` at cycle 10, `stop` at cycle 10+4*7+1 -> `result_ms`=7, `timeout`=0, `result_valid`=1 one cycle after `stop`; `busy` 1 throughout RUN.
2. `start`, no `stop` -> `timeout`=1 and `result_ms`=20 after 84 cycles in RUN; `result_valid` held until `ack`, then low on the next cycle.
3. `start`+`stop` same cycle in IDLE -> RUN entered; a later `stop` gives the correct count. `stop` in IDLE alone -> no state change.
4. In DONE, `start` without `ack` -> ignored, result unchanged. `ack`+`start` same cycle -> `busy`=1 next cycle, new measurement of 3 ms returns 3.
5. `reset` asserted mid-RUN -> all outputs 0 next cycle, state IDLE, no `result_valid`.
6. With INTERVAL_METER_BCD_EN, `stop` at 1234 ms (CLKS_PER_MS=4, MAX_MS=9999) -> `result_bcd`=16'h1234, `result_valid` exactly CNT_W+1 cycles after `stop`.

Source files
------------

// File: rtl/interval_pkg.sv
// Shared types and helpers for the interval meter.
// State CONV is only reachable when INTERVAL_METER_BCD_EN is defined.
package interval_pkg;

    typedef enum logic [1:0] {IDLE, RUN, CONV, DONE} interval_state_t;

    localparam int unsigned BCD_DIGITS = 4;

    // Prescaler width; a 1-bit floor keeps degenerate settings legal.
    function automatic int unsigned presc_width(input int unsigned clks);
        int unsigned w;
        w = $clog2(clks);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per cycle.
// done is high in the cycle of the final step; bcd is valid the cycle after.
module bin2bcd_seq
    import interval_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [CNT_W-1:0]        bin,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    localparam int unsigned BCD_W  = 4 * BCD_DIGITS;
    localparam int unsigned STEP_W = $clog2(CNT_W) + 1;

    logic [CNT_W-1:0]  shift_q;
    logic [BCD_W-1:0]  work_q;
    logic [BCD_W-1:0]  adj;
    logic [BCD_W-1:0]  work_next;
    logic [STEP_W-1:0] step_q;
    logic              active_q;
    logic              last;
    logic [BCD_W-1:0]  bcd_q;

    always_comb begin
        adj = work_q;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (work_q[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
            end
        end
        work_next = {adj[BCD_W-2:0], shift_q[CNT_W-1]};
        last      = active_q && (step_q == STEP_W'(CNT_W - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q  <= '0;
            work_q   <= '0;
            step_q   <= '0;
            active_q <= 1'b0;
            bcd_q    <= '0;
        end else if (load) begin
            shift_q  <= bin;
            work_q   <= '0;
            step_q   <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            shift_q <= shift_q << 1;
            work_q  <= work_next;
            step_q  <= step_q + 1'b1;
            if (last) begin
                active_q <= 1'b0;
                bcd_q    <= work_next;
            end
        end
    end

    assign done = last;
    assign bcd  = bcd_q;

endmodule

// File: rtl/interval_meter.sv
// Millisecond interval meter: start/stop pulses, timeout at MAX_MS, valid/ack result hold.
// Define INTERVAL_METER_BCD_EN to add result_bcd and the CONV state.
module interval_meter
    import interval_pkg::*;
#(
    parameter int unsigned CLKS_PER_MS = 50000,
    parameter int unsigned MAX_MS      = 9999,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             ack,
    output logic             busy,
    output logic             result_valid,
    output logic [CNT_W-1:0] result_ms,
    output logic             timeout
`ifdef INTERVAL_METER_BCD_EN
    ,
    output logic [15:0]      result_bcd
`endif
);

    localparam int unsigned     PW         = presc_width(CLKS_PER_MS);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLKS_PER_MS - 1);
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_MS);

`ifdef INTERVAL_METER_BCD_EN
    localparam interval_state_t LEAVE_RUN = CONV;
    logic bcd_done;
`else
    localparam interval_state_t LEAVE_RUN = DONE;
`endif

    interval_state_t  state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] ms_q, ms_d;
    logic             wrap;
    logic             capture;
    logic [CNT_W-1:0] capture_val;
    logic             capture_to;

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        ms_d        = ms_q;
        capture     = 1'b0;
        capture_val = ms_q;
        capture_to  = 1'b0;
        wrap        = (presc_q == PRESC_LAST);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    presc_d = '0;
                    ms_d    = '0;
                end
            end
            RUN: begin
                presc_d = wrap ? '0 : presc_q + 1'b1;
                // stop takes priority over a same-cycle timeout wrap
                if (stop) begin
                    capture     = 1'b1;
                    capture_val = ms_q;
                end else if (wrap) begin
                    if (ms_q == MAX_CNT) begin
                        capture     = 1'b1;
                        capture_val = MAX_CNT;
                        capture_to  = 1'b1;
                    end else begin
                        ms_d = ms_q + 1'b1;
                    end
                end
                if (capture) begin
                    state_d = LEAVE_RUN;
                end
            end
            CONV: begin
`ifdef INTERVAL_METER_BCD_EN
                if (bcd_done) begin
                    state_d = DONE;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (ack) begin
                    if (start) begin
                        state_d = RUN;
                        presc_d = '0;
                        ms_d    = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            ms_q         <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_ms    <= '0;
            timeout      <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            ms_q         <= ms_d;
            busy         <= (state_d == RUN) || (state_d == CONV);
            result_valid <= (state_d == DONE);
            if (capture) begin
                result_ms <= capture_val;
                timeout   <= capture_to;
            end
        end
    end

`ifdef INTERVAL_METER_BCD_EN
    bin2bcd_seq #(
        .CNT_W (CNT_W)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .load  (capture),
        .bin   (capture_val),
        .done  (bcd_done),
        .bcd   (result_bcd)
    );
`endif

endmodule

// File: tb/tb_interval_meter.sv
// Directed, table-driven bench for interval_meter (CLKS_PER_MS=4).
// With INTERVAL_METER_BCD_EN the timeout section is skipped and a BCD sequence runs.
module tb_interval_meter;

    localparam int unsigned CPM = 4;
    localparam int unsigned CW  = 16;
`ifdef INTERVAL_METER_BCD_EN
    localparam int unsigned MAXM = 9999;
    localparam int          LAT  = 16;
    localparam logic [15:0] PRE5_MS = 16'd3;
`else
    localparam int unsigned MAXM = 20;
    localparam int          LAT  = 0;
    localparam logic [15:0] PRE5_MS = 16'd20;
`endif

    logic          clk;
    logic          reset;
    logic          start;
    logic          stop;
    logic          ack;
    logic          busy;
    logic          result_valid;
    logic [CW-1:0] result_ms;
    logic          timeout;
`ifdef INTERVAL_METER_BCD_EN
    logic [15:0]   result_bcd;
`endif

    interval_meter #(
        .CLKS_PER_MS (CPM),
        .MAX_MS      (MAXM),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .ack          (ack),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ms    (result_ms),
        .timeout      (timeout)
`ifdef INTERVAL_METER_BCD_EN
        ,
        .result_bcd   (result_bcd)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        start;
        logic        stop;
        logic        ack;
        logic        rst;
        int          pre;
        int          post;
        logic        busy;
        logic        valid;
        logic [15:0] ms;
        logic        to;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input string n, input logic s, input logic p, input logic a,
                                input logic r, input int pre, input int post, input logic b,
                                input logic v, input logic [15:0] m, input logic t);
        vec_t e;
        e.name = n; e.start = s; e.stop = p; e.ack = a; e.rst = r;
        e.pre = pre; e.post = post;
        e.busy = b; e.valid = v; e.ms = m; e.to = t;
        vecs.push_back(e);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string n, input string sig, input logic [15:0] act,
                          input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", n, sig, act, exp);
        end
    endtask

    task automatic check_out(input string n, input logic b, input logic v,
                             input logic [15:0] m, input logic t);
        check1(n, "busy", {15'd0, busy}, {15'd0, b});
        check1(n, "result_valid", {15'd0, result_valid}, {15'd0, v});
        check1(n, "result_ms", result_ms, m);
        check1(n, "timeout", {15'd0, timeout}, {15'd0, t});
    endtask

    task automatic apply(input vec_t e);
        repeat (e.pre) cycle();
        start = e.start; stop = e.stop; ack = e.ack; reset = e.rst;
        cycle();
        start = 1'b0; stop = 1'b0; ack = 1'b0; reset = 1'b0;
        repeat (e.post) cycle();
        check_out(e.name, e.busy, e.valid, e.ms, e.to);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; stop = 1'b0; ack = 1'b0;

        //  name               st sp ak rs  pre  post  busy valid ms     to
        add("reset",           0, 0, 0, 1,  0,   0,    0,   0,    16'd0, 0);
        add("t1_start",        1, 0, 0, 0,  8,   0,    1,   0,    16'd0, 0);
        add("t1_mid",          0, 0, 0, 0,  0,   14,   1,   0,    16'd0, 0);
        add("t1_stop",         0, 1, 0, 0,  13,  LAT,  0,   1,    16'd7, 0);
        add("t4_start_no_ack", 1, 0, 0, 0,  2,   0,    0,   1,    16'd7, 0);
        add("t3_ack",          0, 0, 1, 0,  1,   0,    0,   0,    16'd7, 0);
        add("t3_stop_idle",    0, 1, 0, 0,  1,   2,    0,   0,    16'd7, 0);
        add("t3_start_stop",   1, 1, 0, 0,  1,   0,    1,   0,    16'd7, 0);
        add("t3_stop",         0, 1, 0, 0,  8,   LAT,  0,   1,    16'd2, 0);
        add("t4_ack_start",    1, 0, 1, 0,  3,   0,    1,   0,    16'd2, 0);
        add("t4_stop",         0, 1, 0, 0,  12,  LAT,  0,   1,    16'd3, 0);
        add("t4_ack",          0, 0, 1, 0,  0,   0,    0,   0,    16'd3, 0);
`ifndef INTERVAL_METER_BCD_EN
        add("t2_start",        1, 0, 0, 0,  0,   0,    1,   0,    16'd3, 0);
        add("t2_edge",         0, 0, 0, 0,  82,  0,    1,   0,    16'd3, 0);
        add("t2_timeout",      0, 0, 0, 0,  0,   0,    0,   1,    16'd20, 1);
        add("t2_hold",         0, 0, 0, 0,  5,   0,    0,   1,    16'd20, 1);
        add("t2_ack",          0, 0, 1, 0,  0,   0,    0,   0,    16'd20, 1);
        add("wrap_start",      1, 0, 0, 0,  1,   0,    1,   0,    16'd20, 1);
        add("wrap_stop",       0, 1, 0, 0,  83,  0,    0,   1,    16'd20, 0);
        add("wrap_ack",        0, 0, 1, 0,  0,   0,    0,   0,    16'd20, 0);
`endif
        add("t5_start",        1, 0, 0, 0,  2,   0,    1,   0,    PRE5_MS, 0);
        add("t5_reset",        0, 0, 0, 1,  10,  0,    0,   0,    16'd0, 0);
        add("t5_after",        0, 0, 0, 0,  20,  0,    0,   0,    16'd0, 0);
        add("t5_stop_idle",    0, 1, 0, 0,  0,   3,    0,   0,    16'd0, 0);

        repeat (3) cycle();
        check_out("por", 1'b0, 1'b0, 16'd0, 1'b0);
`ifdef INTERVAL_METER_BCD_EN
        check1("por", "result_bcd", result_bcd, 16'h0000);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

`ifdef INTERVAL_METER_BCD_EN
        // 1234 ms: stop lands on edge start+1+4*1234
        start = 1'b1; cycle(); start = 1'b0;
        repeat (4936) cycle();
        stop = 1'b1; cycle(); stop = 1'b0;
        check_out("bcd_conv", 1'b1, 1'b0, 16'd1234, 1'b0);
        n = 0;
        while (!result_valid && n < 100) begin
            cycle();
            n++;
        end
        check1("bcd", "valid_latency", 16'(n), 16'(LAT));
        check1("bcd", "result_bcd", result_bcd, 16'h1234);
        check_out("bcd_done", 1'b0, 1'b1, 16'd1234, 1'b0);
`else
        // bounded latency probe: stop after 5 ms, valid must follow on the next cycle
        start = 1'b1; cycle(); start = 1'b0;
        repeat (20) cycle();
        stop = 1'b1; cycle(); stop = 1'b0;
        n = 0;
        while (!result_valid && n < 50) begin
            cycle();
            n++;
        end
        check1("lat", "valid_latency", 16'(n), 16'd0);
        check_out("lat_done", 1'b0, 1'b1, 16'd5, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
